// File: rtl/jtframe_eeprom_93c_if.sv
// Pin-level bundle of the 93C46-style EEPROM: the Microwire serial link
// driven by the CPU plus the parallel dump port used for NVRAM load/save.
interface jtframe_eeprom_93c_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          scs;
    logic          sclk;
    logic          sdi;
    logic          sdo;
    logic [AW-1:0] dump_addr;
    logic          dump_we;
    logic [DW-1:0] dump_din;
    logic [DW-1:0] dump_dout;

    // Host side: CPU latch and SD-card loader
    modport master (
        output scs, sclk, sdi, dump_addr, dump_we, dump_din,
        input  sdo, dump_dout
    );

    // Memory side: the EEPROM responder
    modport slave (
        input  scs, sclk, sdi, dump_addr, dump_we, dump_din,
        output sdo, dump_dout
    );
endinterface

// File: rtl/jtframe_eeprom_93c.sv
// 93C46-family serial EEPROM responder. The serial pins are slow signals
// oversampled in the clk domain; the word array doubles as the NVRAM image
// exposed through the dump port.
module jtframe_eeprom_93c #(
    parameter int AW          = 6,
    parameter int DW          = 16,
    parameter int BUSY_CYCLES = 96000
) (
    input  logic                 clk,
    input  logic                 rst,
    jtframe_eeprom_93c_if.slave  bus
);
    localparam int WORDS = 1 << AW;
    localparam int CW    = $clog2((DW > AW + 2) ? DW : AW + 2);
    localparam int BW    = $clog2(BUSY_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CMD,
        ST_READ,
        ST_WRITE,
        ST_ARMED,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Synchronizer stage and edge history
    logic scs_reg, sclk_reg, sdi_reg, sclk_prev_reg;

    state_t        state_reg;
    logic          wen_reg;
    logic [BW-1:0] busy_cnt_reg;
    logic          sdo_reg;
    logic [AW:0]   cmd_sr_reg;      // opcode + address minus the bit being sampled
    logic [DW-1:0] data_sr_reg;     // write data, also the program-cycle data
    logic [CW-1:0] bit_cnt_reg;
    logic [AW-1:0] addr_reg;
    logic          all_reg;         // ERAL/WRAL: sweep every word
    logic          wr_pend_reg;
    logic [AW-1:0] sweep_addr_reg;
    logic [DW-1:0] rd_word_reg;
    logic [DW-1:0] dump_dout_reg;

    logic [DW-1:0] mem [0:WORDS-1];

    logic            rise;
    logic [AW+1:0]   cmd_word_next;
    logic [DW-1:0]   data_word_next;
    logic [CW-1:0]   rd_idx;
    logic            int_we;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;

    assign rise           = sclk_reg & ~sclk_prev_reg & scs_reg;
    assign cmd_word_next  = {cmd_sr_reg, sdi_reg};
    assign data_word_next = {data_sr_reg[DW-2:0], sdi_reg};
    assign rd_idx         = CW'(DW - 1) - bit_cnt_reg;

    // Write port arbitration: program cycle owns the array, dump writes are dropped during BUSY
    always_comb begin
        int_we    = (state_reg == ST_BUSY) && wr_pend_reg;
        mem_we    = int_we | (bus.dump_we & (state_reg != ST_BUSY));
        mem_waddr = bus.dump_addr;
        mem_wdata = bus.dump_din;
        if (int_we) begin
            mem_waddr = all_reg ? sweep_addr_reg : addr_reg;
            mem_wdata = data_sr_reg;
        end
    end

    // Register the serial pins once before any protocol decision
    always_ff @(posedge clk) begin
        if (rst) begin
            scs_reg       <= 1'b0;
            sclk_reg      <= 1'b0;
            sdi_reg       <= 1'b0;
            sclk_prev_reg <= 1'b0;
        end else begin
            scs_reg       <= bus.scs;
            sclk_reg      <= bus.sclk;
            sdi_reg       <= bus.sdi;
            sclk_prev_reg <= sclk_reg;
        end
    end

    // Word array: single write port, registered read for the serial reader
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_word_reg <= mem[addr_reg];
    end

    // Registered dump read port
    always_ff @(posedge clk) begin
        if (rst) dump_dout_reg <= '0;
        else     dump_dout_reg <= mem[bus.dump_addr];
    end

    // Microwire protocol FSM with registered sdo
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wen_reg        <= 1'b0;
            busy_cnt_reg   <= '0;
            sdo_reg        <= 1'b1;
            cmd_sr_reg     <= '0;
            data_sr_reg    <= '0;
            bit_cnt_reg    <= '0;
            addr_reg       <= '0;
            all_reg        <= 1'b0;
            wr_pend_reg    <= 1'b0;
            sweep_addr_reg <= '0;
        end else if (state_reg == ST_BUSY) begin
            // Program cycle runs regardless of scs; sdo reports busy only while selected
            sdo_reg      <= ~scs_reg;
            busy_cnt_reg <= busy_cnt_reg - BW'(1);
            if (busy_cnt_reg <= BW'(1)) begin
                busy_cnt_reg <= '0;
                state_reg    <= ST_IDLE;
                sdo_reg      <= 1'b1;
            end
            if (wr_pend_reg) begin
                sweep_addr_reg <= sweep_addr_reg + AW'(1);
                if (!all_reg || sweep_addr_reg == AW'(WORDS - 1))
                    wr_pend_reg <= 1'b0;
            end
        end else if (!scs_reg) begin
            // Deselect aborts anything incomplete; a fully shifted write starts programming
            sdo_reg <= 1'b1;
            if (state_reg == ST_ARMED) begin
                state_reg      <= ST_BUSY;
                busy_cnt_reg   <= BW'(BUSY_CYCLES);
                wr_pend_reg    <= 1'b1;
                sweep_addr_reg <= '0;
            end else begin
                state_reg <= ST_IDLE;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    sdo_reg   <= 1'b1;
                    state_reg <= ST_START;
                end
                ST_START: begin
                    if (rise && sdi_reg) begin
                        state_reg   <= ST_CMD;
                        bit_cnt_reg <= '0;
                        cmd_sr_reg  <= '0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_sr_reg  <= cmd_word_next[AW:0];
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                        if (bit_cnt_reg == CW'(AW + 1)) begin
                            bit_cnt_reg <= '0;
                            addr_reg    <= cmd_word_next[AW-1:0];
                            case (cmd_word_next[AW+1:AW])
                                2'b10: begin
                                    state_reg <= ST_READ;
                                    sdo_reg   <= 1'b0;
                                end
                                2'b01: begin
                                    all_reg   <= 1'b0;
                                    state_reg <= ST_WRITE;
                                end
                                2'b11: begin
                                    all_reg     <= 1'b0;
                                    data_sr_reg <= '1;
                                    state_reg   <= wen_reg ? ST_ARMED : ST_DONE;
                                end
                                default: begin
                                    case (cmd_word_next[AW-1:AW-2])
                                        2'b11: begin
                                            wen_reg   <= 1'b1;
                                            state_reg <= ST_DONE;
                                        end
                                        2'b00: begin
                                            wen_reg   <= 1'b0;
                                            state_reg <= ST_DONE;
                                        end
                                        2'b10: begin
                                            all_reg     <= 1'b1;
                                            data_sr_reg <= '1;
                                            state_reg   <= wen_reg ? ST_ARMED : ST_DONE;
                                        end
                                        default: begin
                                            all_reg   <= 1'b1;
                                            state_reg <= ST_WRITE;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                ST_READ: begin
                    // Stream words MSB first; the array read follows addr_reg within two clks
                    if (rise) begin
                        sdo_reg <= rd_word_reg[rd_idx];
                        if (bit_cnt_reg == CW'(DW - 1)) begin
                            bit_cnt_reg <= '0;
                            addr_reg    <= addr_reg + AW'(1);
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (rise) begin
                        data_sr_reg <= data_word_next;
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                        if (bit_cnt_reg == CW'(DW - 1)) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= wen_reg ? ST_ARMED : ST_DONE;
                        end
                    end
                end
                ST_ARMED, ST_DONE: begin
                    sdo_reg <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.sdo       = sdo_reg;
    assign bus.dump_dout = dump_dout_reg;

endmodule

// File: tb/tb_jtframe_eeprom_93c.sv
// Directed bench for jtframe_eeprom_93c: bit-banged Microwire commands,
// a word model of the array and a queue of expected serial read words.
module tb_jtframe_eeprom_93c;
    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int BUSY  = 200;
    localparam int WORDS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtframe_eeprom_93c_if #(.AW(AW), .DW(DW)) bus ();

    jtframe_eeprom_93c #(.AW(AW), .DW(DW), .BUSY_CYCLES(BUSY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] model [0:WORDS-1];
    logic [15:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One serial bit: sdi set while sclk low, sdo sampled late in the high phase
    task automatic sbit(input logic b, output logic o);
        @(negedge clk);
        bus.sdi  = b;
        bus.sclk = 1'b0;
        repeat (3) @(negedge clk);
        bus.sclk = 1'b1;
        repeat (4) @(negedge clk);
        o = bus.sdo;
        bus.sclk = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        logic o;
        for (int i = n - 1; i >= 0; i--) sbit(v[i], o);
    endtask

    task automatic begin_cmd(input logic [1:0] op, input logic [5:0] a);
        @(negedge clk);
        bus.scs = 1'b1;
        repeat (3) @(negedge clk);
        send(32'h0, 2);           // leading zeros before the start bit
        send(32'h1, 1);
        send({24'h0, op, a}, 8);
    endtask

    task automatic drop_scs();
        @(negedge clk);
        bus.scs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // scs low for one clk then high again; count clks with sdo reporting busy
    task automatic end_cmd_measure(output int zeros, output logic timeout);
        zeros   = 0;
        timeout = 1'b1;
        @(negedge clk);
        bus.scs = 1'b0;
        @(negedge clk);
        bus.scs = 1'b1;
        for (int c = 0; c < BUSY + 50; c++) begin
            @(negedge clk);
            if (bus.sdo === 1'b0) zeros++;
            else if (zeros > 0 || c >= 8) begin
                timeout = 1'b0;
                break;
            end
        end
        drop_scs();
    endtask

    task automatic dump_wr(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.dump_addr = a;
        bus.dump_din  = d;
        bus.dump_we   = 1'b1;
        @(negedge clk);
        bus.dump_we   = 1'b0;
    endtask

    task automatic dump_rd(input logic [5:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.dump_addr = a;
        @(negedge clk);
        d = bus.dump_dout;
    endtask

    // Serial READ of n consecutive words starting at a
    task automatic read_check(input logic [5:0] a, input int n, input string tag);
        logic        o;
        logic [15:0] w;
        logic [15:0] e;
        logic [5:0]  ai;
        @(negedge clk);
        bus.scs = 1'b1;
        repeat (3) @(negedge clk);
        send(32'h1, 1);
        send({25'h0, 2'b10, a[5:1]}, 7);
        for (int k = 0; k < n; k++) begin
            ai = a + 6'(k);
            exp_q.push_back(model[ai]);
        end
        sbit(a[0], o);
        chk({tag, "_dummy"}, {31'h0, o}, 32'h0);
        for (int k = 0; k < n; k++) begin
            for (int b = 15; b >= 0; b--) begin
                sbit(1'b0, o);
                w[b] = o;
            end
            e = exp_q.pop_front();
            $display("txn read addr=%0h word=%0h", a + 6'(k), w);
            chk(tag, {16'h0, w}, {16'h0, e});
        end
        drop_scs();
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d,
                              output int zeros, output logic timeout);
        begin_cmd(2'b01, a);
        send({16'h0, d}, 16);
        end_cmd_measure(zeros, timeout);
        $display("txn write addr=%0h data=%0h busy_clks=%0d", a, d, zeros);
    endtask

    initial begin
        int          zeros;
        logic        tmo;
        logic [15:0] d;

        bus.scs = 1'b0; bus.sclk = 1'b0; bus.sdi = 1'b0;
        bus.dump_addr = '0; bus.dump_we = 1'b0; bus.dump_din = '0;

        repeat (4) @(negedge clk);
        chk("reset_sdo", {31'h0, bus.sdo}, 32'h1);
        chk("reset_dump_dout", {16'h0, bus.dump_dout}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Load the image through the dump port
        for (int a = 0; a < WORDS; a++) begin
            d = 16'(a ^ 'hA5);
            dump_wr(6'(a), d);
            model[a] = d;
        end
        $display("txn dump load 64 words");
        dump_rd(6'h03, d);
        chk("dump_rd3", {16'h0, d}, 32'h00A6);

        read_check(6'h00, WORDS, "read_all");
        read_check(6'h3F, 2, "read_wrap");

        // EWEN then a programmed write
        begin_cmd(2'b00, 6'b110000);
        drop_scs();
        $display("txn ewen");
        write_word(6'h05, 16'h1234, zeros, tmo);
        model[5] = 16'h1234;
        chk("write_busy_tmo", {31'h0, tmo}, 32'h0);
        chk("write_busy_clks", zeros, BUSY - 1);
        dump_rd(6'h05, d);
        chk("write_dump5", {16'h0, d}, 32'h1234);
        read_check(6'h05, 2, "read_after_write");

        // EWDS blocks writes
        begin_cmd(2'b00, 6'b000000);
        drop_scs();
        $display("txn ewds");
        write_word(6'h05, 16'hBEEF, zeros, tmo);
        chk("ewds_busy_clks", zeros, 0);
        dump_rd(6'h05, d);
        chk("ewds_dump5", {16'h0, d}, 32'h1234);

        // WRAL then ERAL
        begin_cmd(2'b00, 6'b110000);
        drop_scs();
        begin_cmd(2'b00, 6'b010000);
        send(32'hA5A5, 16);
        end_cmd_measure(zeros, tmo);
        $display("txn wral data=a5a5 busy_clks=%0d", zeros);
        chk("wral_busy_clks", zeros, BUSY - 1);
        for (int a = 0; a < WORDS; a++) model[a] = 16'hA5A5;
        for (int a = 0; a < WORDS; a++) begin
            dump_rd(6'(a), d);
            chk("wral_word", {16'h0, d}, {16'h0, model[a]});
        end
        begin_cmd(2'b00, 6'b100000);
        end_cmd_measure(zeros, tmo);
        $display("txn eral busy_clks=%0d", zeros);
        chk("eral_busy_clks", zeros, BUSY - 1);
        for (int a = 0; a < WORDS; a++) model[a] = 16'hFFFF;
        for (int a = 0; a < WORDS; a++) begin
            dump_rd(6'(a), d);
            chk("eral_word", {16'h0, d}, {16'h0, model[a]});
        end

        // Aborted write: scs falls after 8 data bits
        begin_cmd(2'b01, 6'h07);
        send(32'h00, 8);
        end_cmd_measure(zeros, tmo);
        $display("txn aborted write addr=07 busy_clks=%0d", zeros);
        chk("abort_busy_clks", zeros, 0);
        dump_rd(6'h07, d);
        chk("abort_dump7", {16'h0, d}, 32'hFFFF);

        // Dump write during BUSY is dropped
        begin_cmd(2'b01, 6'h07);
        send(32'h1357, 16);
        @(negedge clk); bus.scs = 1'b0;
        @(negedge clk); bus.scs = 1'b1;
        repeat (10) @(negedge clk);
        dump_wr(6'h09, 16'h0000);
        tmo = 1'b1;
        for (int c = 0; c < BUSY + 50; c++) begin
            @(negedge clk);
            if (bus.sdo === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        drop_scs();
        $display("txn write addr=07 data=1357 with dump write addr=09 in busy");
        chk("busy_dump_tmo", {31'h0, tmo}, 32'h0);
        model[7] = 16'h1357;
        dump_rd(6'h07, d);
        chk("busy_write7", {16'h0, d}, 32'h1357);
        dump_rd(6'h09, d);
        chk("busy_dump_dropped9", {16'h0, d}, 32'hFFFF);

        // Reset in the middle of a program cycle
        begin_cmd(2'b01, 6'h05);
        send(32'h4444, 16);
        @(negedge clk); bus.scs = 1'b0;
        @(negedge clk); bus.scs = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        zeros = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.sdo !== 1'b1) zeros++;
        end
        $display("txn reset during busy");
        chk("rst_busy_sdo_zero_clks", zeros, 0);
        drop_scs();
        write_word(6'h0A, 16'h0000, zeros, tmo);
        chk("rst_wen_cleared_busy", zeros, 0);
        read_check(6'h0A, 1, "rst_wen_cleared_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
